// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with hex/decimal decode,
// leading-zero blanking and frame-synchronous (tear-free) value updates.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int HEX_EN     = 1,
  parameter int ACTIVE_LOW = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic          POL     = (ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, pend_q, pend_d;
  logic                    pend_v_q, pend_v_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    tick, fb;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick = en && (cnt_q == CNT_MAX);
  assign fb   = tick && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A load on the boundary edge goes straight to shadow; otherwise it is parked.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (fb) begin
      shadow_d = load ? value : (pend_v_q ? pend_q : shadow_q);
      pend_v_d = 1'b0;
    end else if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin : lz_scan
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (shadow_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      lz_blank[NUM_DIGITS-1-k] = zero_run && (k != NUM_DIGITS - 1);
    end
  end

  always_comb begin : out_sel
    logic [3:0] nib;
    logic       blk;
    logic       dp_sel;
    logic [NUM_DIGITS-1:0] onehot;
    nib    = '0;
    blk    = 1'b0;
    dp_sel = 1'b0;
    onehot = '0;
    seg_d  = '0;
    dp_d   = 1'b0;
    an_d   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        onehot[i] = 1'b1;
        nib       = shadow_q[4*i +: 4];
        blk       = blank_lz && lz_blank[i];
        dp_sel    = dp_in[i];
      end
    end
    if (en && !tick) begin
      an_d = onehot;
      dp_d = dp_sel;
      if (!blk && ((HEX_EN != 0) || (nib <= 4'd9)))
        seg_d = decode(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      seg_q    <= {7{POL}};
      dp_q     <= POL;
      an_q     <= {NUM_DIGITS{POL}};
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      seg_q    <= seg_d ^ {7{POL}};
      dp_q     <= dp_d ^ POL;
      an_q     <= an_d ^ {NUM_DIGITS{POL}};
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule
